// File: rtl/sd_resp_pkg.sv
// Shared state encoding and sector constants for the simulation-side SD block responder.
package sd_resp_pkg;

    typedef enum logic [2:0] {IDLE, ACK, READ, WRITE, GAP} state_t;

    localparam int         BLK_BYTES  = 512;
    localparam int         BLK_SHIFT  = 9;
    localparam logic [8:0] LAST_BYTE  = 9'd511;
    localparam int         GAP_CYCLES = 2;

endpackage

// File: rtl/sd_resp_stream.sv
// Byte counter and address generation for one 512-byte sector burst, with the
// one-cycle alignment between the image memory and the core's buffer port.
module sd_resp_stream
    import sd_resp_pkg::*;
#(
    parameter int IMG_AW = 18
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              dir_wr,
    input  logic              drop,
    input  logic [IMG_AW-1:0] base,
    input  logic [7:0]        img_dout,
    input  logic [7:0]        sd_buff_din,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    output logic [IMG_AW-1:0] img_addr,
    output logic              img_we,
    output logic [7:0]        img_din,
    output logic              last
);

    logic       vld_p0, vld_p1;
    logic [8:0] cnt_p0, cnt_p1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            cnt_p0 <= '0;
            cnt_p1 <= '0;
        end else begin
            // p0: address phase (read image address / write buffer address)
            if (start) begin
                vld_p0 <= 1'b1;
                cnt_p0 <= '0;
            end else if (vld_p0) begin
                cnt_p0 <= cnt_p0 + 9'd1;
                if (cnt_p0 == LAST_BYTE)
                    vld_p0 <= 1'b0;
            end
            // p1: data phase, one cycle behind, matching both memories' latency
            vld_p1 <= vld_p0;
            cnt_p1 <= cnt_p0;
        end
    end

    // Reads address the image in p0; writes address the core buffer in p0 and the image in p1.
    assign sd_buff_addr = dir_wr ? cnt_p0 : cnt_p1;
    assign img_addr     = base + {{(IMG_AW-9){1'b0}}, (dir_wr ? cnt_p1 : cnt_p0)};

    assign sd_buff_wr   = vld_p1 && !dir_wr;
    assign sd_buff_dout = (sd_buff_wr && !drop) ? img_dout : 8'h00;
    assign img_we       = vld_p1 && dir_wr && !drop;
    assign img_din      = img_we ? sd_buff_din : 8'h00;
    assign last         = vld_p1 && (cnt_p1 == LAST_BYTE);

endmodule

// File: rtl/sd_block_responder.sv
// Answers one drive's sd_lba/sd_rd/sd_wr sector handshake from a byte-addressed image memory.
// Define SD_RESP_LATENCY_EN to hold sd_ack low for ACK_DELAY cycles before each transfer.
module sd_block_responder
    import sd_resp_pkg::*;
#(
    parameter int IMG_AW    = 18,
    parameter int ACK_DELAY = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [7:0]        img_dout,
    output logic              img_we,
    output logic [7:0]        img_din,
    input  logic              mount_req,
    input  logic [63:0]       mount_size,
    input  logic              mount_ro,
    output logic              img_mounted,
    output logic [63:0]       img_size,
    output logic              img_readonly,
    output logic              xfer_err
);

    state_t            state;
    logic [IMG_AW-1:0] base;
    logic              dir_wr, drop;
    logic              mnt_pend, pend_ro;
    logic [63:0]       pend_size;
    logic [1:0]        gap_cnt;
    logic              start, last;

`ifdef SD_RESP_LATENCY_EN
    localparam int   DLY_W      = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic ACK_AT_REQ = (ACK_DELAY == 0);
    logic [DLY_W-1:0] dly_cnt;
`else
    // ACK_DELAY only takes effect when the latency option is compiled in.
    localparam logic ACK_AT_REQ = 1'b1 | (ACK_DELAY != 0);
`endif

    // A mount arriving in the same IDLE cycle as a request already governs that request.
    logic [63:0] eff_size;
    logic        eff_ro;
    always_comb begin
        eff_size = img_size;
        eff_ro   = img_readonly;
        if (state == IDLE) begin
            if (mount_req) begin
                eff_size = mount_size;
                eff_ro   = mount_ro;
            end else if (mnt_pend) begin
                eff_size = pend_size;
                eff_ro   = pend_ro;
            end
        end
    end

    // Range is judged on the full byte address so high sectors cannot alias into the image.
    logic [40:0] req_byte;
    logic [63:0] req_end;
    logic        req_oor;
    assign req_byte = {sd_lba, {BLK_SHIFT{1'b0}}};
    assign req_end  = {23'd0, req_byte} + 64'(BLK_BYTES - 1);
    assign req_oor  = (eff_size == 64'd0) || (req_end >= eff_size);

    assign start = (state == ACK) && sd_ack;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            sd_ack       <= 1'b0;
            base         <= '0;
            dir_wr       <= 1'b0;
            drop         <= 1'b0;
            mnt_pend     <= 1'b0;
            pend_size    <= '0;
            pend_ro      <= 1'b0;
            img_size     <= '0;
            img_readonly <= 1'b0;
            img_mounted  <= 1'b0;
            xfer_err     <= 1'b0;
            gap_cnt      <= '0;
`ifdef SD_RESP_LATENCY_EN
            dly_cnt      <= '0;
`endif
        end else begin
            img_mounted <= 1'b0;
            case (state)
                IDLE: begin
                    if (mount_req || mnt_pend) begin
                        img_size     <= eff_size;
                        img_readonly <= eff_ro;
                        img_mounted  <= 1'b1;
                        mnt_pend     <= 1'b0;
                    end
                    if (sd_rd || sd_wr) begin
                        state  <= ACK;
                        base   <= req_byte[IMG_AW-1:0];
                        dir_wr <= !sd_rd;
                        drop   <= req_oor || (!sd_rd && eff_ro);
                        sd_ack <= ACK_AT_REQ;
`ifdef SD_RESP_LATENCY_EN
                        dly_cnt <= '0;
`endif
                    end
                end
                ACK: begin
                    if (sd_ack) begin
                        state <= dir_wr ? WRITE : READ;
                        if (drop)
                            xfer_err <= 1'b1;
                    end
`ifdef SD_RESP_LATENCY_EN
                    else if (!(dir_wr ? sd_wr : sd_rd))
                        state <= IDLE;
                    else if (dly_cnt == DLY_W'(ACK_DELAY - 1))
                        sd_ack <= 1'b1;
                    else
                        dly_cnt <= dly_cnt + 1'b1;
`endif
                end
                READ, WRITE: begin
                    if (last) begin
                        sd_ack  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 2'(GAP_CYCLES - 1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
            // Mounts outside IDLE wait; a later one replaces an earlier one.
            if (mount_req && state != IDLE) begin
                mnt_pend  <= 1'b1;
                pend_size <= mount_size;
                pend_ro   <= mount_ro;
            end
        end
    end

    sd_resp_stream #(.IMG_AW(IMG_AW)) u_stream (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .start        (start),
        .dir_wr       (dir_wr),
        .drop         (drop),
        .base         (base),
        .img_dout     (img_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .img_addr     (img_addr),
        .img_we       (img_we),
        .img_din      (img_din),
        .last         (last)
    );

endmodule
